// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around the add1 full-adder cell, LSB first.
// Optional abort input enabled by SERIAL_ADD_ABORT_EN.

module add1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef SERIAL_ADD_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, w_opa_nxt;
  logic [WIDTH-1:0] r_opb, w_opb_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic             r_carry, w_carry_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_zero, w_zero_nxt;

  logic             w_sum;
  logic             w_co;
  logic             w_last;
  logic             w_abort;
  logic [WIDTH-1:0] w_sh_shift;

  add1 u_add1 (
    .i_a  (r_opa[0]),
    .i_b  (r_opb[0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

`ifdef SERIAL_ADD_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_sh_shift = {w_sum, r_sh[WIDTH-1:1]};

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sh     <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_opa    <= w_opa_nxt;
      r_opb    <= w_opb_nxt;
      r_sh     <= w_sh_nxt;
      r_carry  <= w_carry_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_cout   <= w_cout_nxt;
      r_ovf    <= w_ovf_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  // Next-state and next-output logic; flags only move on the final bit.
  always_comb begin
    w_state_nxt  = r_state;
    w_opa_nxt    = r_opa;
    w_opb_nxt    = r_opb;
    w_sh_nxt     = r_sh;
    w_carry_nxt  = r_carry;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_cout_nxt   = r_cout;
    w_ovf_nxt    = r_ovf;
    w_zero_nxt   = r_zero;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_opa_nxt   = a;
          w_opb_nxt   = sub ? ~b : b;
          w_carry_nxt = sub;
          w_cnt_nxt   = '0;
          w_sh_nxt    = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_opa_nxt   = r_opa >> 1;
          w_opb_nxt   = r_opb >> 1;
          w_sh_nxt    = w_sh_shift;
          w_carry_nxt = w_co;
          w_cnt_nxt   = r_cnt + CW'(1);
          if (w_last) begin
            // r_carry is the carry into the MSB on this bit
            w_result_nxt = w_sh_shift;
            w_cout_nxt   = w_co;
            w_ovf_nxt    = r_carry ^ w_co;
            w_zero_nxt   = (w_sh_shift == '0);
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed vectors, monitor checks each done pulse.

module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
`ifdef SERIAL_ADD_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  exp_t             q[$];
  int               n_vec;
  int               n_err;
  int               n_done;
  logic [WIDTH-1:0] last_result;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sub    (sub),
`ifdef SERIAL_ADD_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also guards result stability while busy.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'(result), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_flags", 32'({result, cout, ovf, zero}), 32'({e.res, e.c, e.v, e.z}));
      end
    end
    if (rst_n && busy)
      check("result_stable", 32'(result), 32'(last_result));
    last_result = result;
  end

  // Launch one op; samples #1 after each edge, cycle 1 is the one right after the start edge.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic isub, input exp_t e, input bit inject);
    int busy_cnt;
    int done_at;
    q.push_back(e);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); sub = ~isub;
    busy_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= int'(WIDTH) + 4; k++) begin
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = k;
      start = inject && (k == 3 || done);
      if (start) begin a = 8'h11; b = 8'h11; sub = 1'b0; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
    check("done_latency", 32'(done_at), 32'(WIDTH + 1));
  endtask

  initial begin
    int d0;
    n_vec = 0; n_err = 0; n_done = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
`ifdef SERIAL_ADD_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, result, cout, ovf, zero}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h3C, 8'h25, 1'b0, '{8'h61, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}, 1'b0);
    run_op(8'h05, 8'h05, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1}, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b1, 1'b0}, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, '{8'hFF, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op(8'hC8, 8'hC8, 1'b0, '{8'h90, 1'b1, 1'b0, 1'b0}, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b1}, 1'b0);

    // start pulses during RUN and DONE must be ignored
    d0 = n_done;
    run_op(8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0, 1'b0}, 1'b1);
    check("single_done", 32'(n_done - d0), 32'd1);
    check("idle_after_ignored", 32'(busy), 32'd0);

    // Synchronous reset in the middle of an operation
    d0 = n_done;
    a = 8'h3C; b = 8'h25; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midop_reset", 32'({busy, done, result, cout, ovf, zero}), 32'h0);
    repeat (int'(WIDTH) + 4) begin @(posedge clk); #1; end
    check("no_done_after_reset", 32'(n_done - d0), 32'd0);

`ifdef SERIAL_ADD_ABORT_EN
    run_op(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}, 1'b0);
    d0 = n_done;
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'({busy, done}), 32'h0);
    check("abort_keeps", 32'({result, cout, ovf, zero}), 32'({8'h80, 1'b0, 1'b1, 1'b0}));
    repeat (int'(WIDTH) + 4) begin @(posedge clk); #1; end
    check("no_done_after_abort", 32'(n_done - d0), 32'd0);
`endif

    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial sequencer that drives the team's 1-bit full-adder cell (add1) and collects its sum/cout outputs to form a WIDTH-bit add/subtract result.
- Processes one bit per clock, LSB first. Trades latency for area against the ripple 8-bit adder path in the ALU.
- Uses a start/busy/done handshake so the ALU control FSM can launch an operation and poll for completion.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values 2..32).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- sub  input  1  0 = A+B, 1 = A−B (A + ~B + 1); captured on the accepted start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse: result and flags are valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- cout  output  1  raw carry out of the MSB (for subtract, 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  1 when result == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk. It has priority over all other inputs.
- Reset values: state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0, zero=0; carry flop=0; bit counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load opA=a, opB=(sub ? ~b : b), carry=sub, counter=0, clear result shift register; go to RUN.
  - start=0 → stay in IDLE; outputs hold.
- RUN (busy=1), each cycle:
  - Full-adder inputs: opA[0], opB[0], carry.
  - sum shifts into the result MSB (result shifts right by 1); opA and opB shift right by 1.
  - carry ← adder cout; counter increments.
- Final bit:
  - When counter == WIDTH−1, latch carry-in of this bit as cin_msb.
  - cout ← adder cout; ovf ← cin_msb ^ adder cout; zero evaluated on the final result value.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; unconditionally return to IDLE.
- Latency: start sampled at edge N → busy high in cycles N+1..N+WIDTH → done high in cycle N+WIDTH+1. Throughput: one operation per WIDTH+2 cycles.
- result, cout, ovf, zero change only on the RUN→DONE transition (the result shift register is internal), so they stay stable while busy=1.
- start while in RUN or DONE: ignored, not queued.
- a, b, sub changing after acceptance: no effect.
- Reset mid-operation: synchronous return to IDLE with all reset values; no done pulse.
- Arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: SERIAL_ADD_ABORT_EN
- Defined:
  - Adds input port abort (1 bit) after sub.
  - abort=1 in RUN → next state IDLE, busy=0, no done pulse; result, cout, ovf, zero keep their prior values.
  - abort is ignored in IDLE and DONE.
  - abort and start both high in IDLE → start wins.
- Undefined: abort port absent; every accepted operation runs to completion.

Test Plan:
- Add, no flags: a=0x3C, b=0x25, sub=0, start → done at cycle 9 after the start edge; result=0x61, cout=0, ovf=0, zero=0; busy high exactly 8 cycles.
- Signed overflow: a=0x7F, b=0x01, sub=0 → result=0x80, cout=0, ovf=1, zero=0.
- Wrap to zero: a=0xFF, b=0x01, sub=0 → result=0x00, cout=1, ovf=0, zero=1. Subtract: a=0x05, b=0x05, sub=1 → result=0x00, cout=1, ovf=0, zero=1.
- Subtract overflow and borrow: a=0x80, b=0x01, sub=1 → result=0x7F, cout=1, ovf=1. Then a=0x01, b=0x02, sub=1 → result=0xFF, cout=0, ovf=0.
- Start pulsed at RUN cycles 3 and DONE with a=0x11, b=0x11 → ignored; the original operation's result is unchanged and exactly one done pulse occurs.
- rst_n=0 for one cycle at RUN cycle 4 → next cycle busy=0, done=0, result=0, all flags 0; no done pulse afterwards. With SERIAL_ADD_ABORT_EN: abort at RUN cycle 4 → IDLE, previous result retained, no done pulse.
